// File: rtl/muntjac_pkg.sv
// Shared Muntjac types: branch type encoding and the BTB training request payload.
package muntjac_pkg;

  typedef enum logic [2:0] {
    BRANCH_NONE    = 3'b000,
    BRANCH_YIELD   = 3'b001,
    BRANCH_UNTAKEN = 3'b010,
    BRANCH_TAKEN   = 3'b011,
    BRANCH_JUMP    = 3'b100,
    BRANCH_CALL    = 3'b101,
    BRANCH_RET     = 3'b110
  } branch_type_e;

  // Widest supported address; narrower cores zero-extend into the payload.
  localparam int unsigned BtbAddrLen = 64;

  typedef struct packed {
    logic [BtbAddrLen-1:0] pc;
    branch_type_e          branch_type;
    logic                  partial;
    logic [BtbAddrLen-1:0] npc;
  } btb_train_req_t;

  typedef enum logic [1:0] {
    TRAIN_NONE,
    TRAIN_ALLOC,
    TRAIN_RETARGET,
    TRAIN_INVALIDATE
  } train_action_e;

endpackage

// File: rtl/muntjac_btb_train_queue.sv
// Circular FIFO with an extra wrap bit on each pointer and in-place overwrite of the newest entry.
module muntjac_btb_train_queue #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  logic overwrite_i,
  input  T     data_i,
  input  logic pop_i,
  output logic valid_o,
  output T     head_o,
  output T     newest_o,
  output logic full_o,
  output logic drop_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]   wptr_q, rptr_q, count;
  logic [PtrW-1:0] newest_idx;
  logic            empty, pop_en, ow_en, push_en;
  T                mem_q [Depth];

  assign count      = wptr_q - rptr_q;
  assign empty      = (wptr_q == rptr_q);
  assign full_o     = (count == (PtrW+1)'(Depth));
  assign valid_o    = !empty;
  assign newest_idx = wptr_q[PtrW-1:0] - 1'b1;
  assign head_o     = mem_q[rptr_q[PtrW-1:0]];
  assign newest_o   = mem_q[newest_idx];

  assign pop_en  = pop_i && !empty;
  // The newest slot cannot be reused once it is leaving as the last head.
  assign ow_en   = push_i && overwrite_i && !empty && !(pop_en && count == (PtrW+1)'(1));
  assign push_en = push_i && !ow_en && (!full_o || pop_en);
  assign drop_o  = push_i && !ow_en && full_o && !pop_en && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until a pointer covers it.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      if (push_en)    mem_q[wptr_q[PtrW-1:0]] <= data_i;
      else if (ow_en) mem_q[newest_idx]       <= data_i;
    end
  end

endmodule

// File: rtl/muntjac_btb_trainer.sv
// Compares resolved control flow with the fetch-time BTB prediction and queues BTB updates.
// Optional counters: define MUNTJAC_BTB_TRAIN_STATS_EN.
module muntjac_btb_trainer
  import muntjac_pkg::*;
#(
  parameter int unsigned AddrLen    = 64,
  parameter int unsigned QueueDepth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               resolve_valid_i,
  input  logic [AddrLen-1:0] resolve_pc_i,
  input  branch_type_e       resolve_branch_type_i,
  input  logic               resolve_partial_i,
  input  logic               resolve_taken_i,
  input  logic [AddrLen-1:0] resolve_npc_i,
  input  logic               pred_hit_i,
  input  logic [AddrLen-1:0] pred_npc_i,
  input  logic               flush_i,
  input  logic               train_ready_i,
  output logic               train_valid_o,
  output branch_type_e       train_branch_type_o,
  output logic [AddrLen-1:0] train_pc_o,
  output logic               train_partial_o,
  output logic [AddrLen-1:0] train_npc_o,
  output logic               queue_full_o
`ifdef MUNTJAC_BTB_TRAIN_STATS_EN
  ,
  output logic [31:0]        stat_trained_o,
  output logic [31:0]        stat_dropped_o
`endif
);

  train_action_e  action;
  btb_train_req_t req, head, newest;
  logic           npc_match, coalesce, q_valid, q_drop;

  assign npc_match = (resolve_npc_i[AddrLen-1:1] == pred_npc_i[AddrLen-1:1]);

  always_comb begin
    action = TRAIN_NONE;
    if (resolve_valid_i) begin
      if (resolve_taken_i && !pred_hit_i)     action = TRAIN_ALLOC;
      else if (resolve_taken_i && !npc_match) action = TRAIN_RETARGET;
      else if (!resolve_taken_i && pred_hit_i) action = TRAIN_INVALIDATE;
    end
  end

  always_comb begin
    req             = '0;
    req.pc          = BtbAddrLen'(resolve_pc_i);
    req.partial     = resolve_partial_i;
    req.branch_type = resolve_branch_type_i;
    req.npc         = BtbAddrLen'({resolve_npc_i[AddrLen-1:1], 1'b0});
    if (action == TRAIN_INVALIDATE) begin
      req.branch_type = BRANCH_NONE;
      req.npc         = '0;
    end
  end

  // Same 4-byte slot as the newest queued entry: the later outcome supersedes it.
  assign coalesce = (newest.pc[AddrLen-1:2] == resolve_pc_i[AddrLen-1:2]);

  muntjac_btb_train_queue #(
    .Depth (QueueDepth),
    .T     (btb_train_req_t)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (action != TRAIN_NONE),
    .overwrite_i (coalesce),
    .data_i      (req),
    .pop_i       (train_ready_i),
    .valid_o     (q_valid),
    .head_o      (head),
    .newest_o    (newest),
    .full_o      (queue_full_o),
    .drop_o      (q_drop)
  );

  assign train_valid_o       = q_valid;
  assign train_branch_type_o = q_valid ? head.branch_type : BRANCH_NONE;
  assign train_pc_o          = q_valid ? head.pc[AddrLen-1:0] : '0;
  assign train_partial_o     = q_valid ? head.partial : 1'b0;
  assign train_npc_o         = q_valid ? head.npc[AddrLen-1:0] : '0;

  logic unused_bits;
  assign unused_bits = ^{newest.branch_type, newest.partial, newest.npc, newest.pc[1:0],
                         resolve_npc_i[0], pred_npc_i[0]};

`ifdef MUNTJAC_BTB_TRAIN_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_trained_o <= '0;
      stat_dropped_o <= '0;
    end else begin
      if (train_valid_o && train_ready_i && stat_trained_o != '1)
        stat_trained_o <= stat_trained_o + 32'd1;
      if (q_drop && stat_dropped_o != '1)
        stat_dropped_o <= stat_dropped_o + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = q_drop;
`endif

endmodule

// File: tb/tb_muntjac_btb_trainer.sv
// Randomised bench for muntjac_btb_trainer against a queue-level reference model.
module tb_muntjac_btb_trainer;
  import muntjac_pkg::*;

  localparam int DEPTH = 4;

  logic         clk = 1'b0, rst_ni = 1'b0;
  logic         resolve_valid_i = 1'b0, resolve_partial_i = 1'b0, resolve_taken_i = 1'b0;
  logic [63:0]  resolve_pc_i = '0, resolve_npc_i = '0, pred_npc_i = '0;
  branch_type_e resolve_branch_type_i = BRANCH_NONE;
  logic         pred_hit_i = 1'b0, flush_i = 1'b0, train_ready_i = 1'b1;
  logic         train_valid_o, train_partial_o, queue_full_o;
  branch_type_e train_branch_type_o;
  logic [63:0]  train_pc_o, train_npc_o;
`ifdef MUNTJAC_BTB_TRAIN_STATS_EN
  logic [31:0]  stat_trained_o, stat_dropped_o;
`endif

  muntjac_btb_trainer #(.AddrLen(64), .QueueDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .resolve_valid_i(resolve_valid_i), .resolve_pc_i(resolve_pc_i),
    .resolve_branch_type_i(resolve_branch_type_i), .resolve_partial_i(resolve_partial_i),
    .resolve_taken_i(resolve_taken_i), .resolve_npc_i(resolve_npc_i),
    .pred_hit_i(pred_hit_i), .pred_npc_i(pred_npc_i),
    .flush_i(flush_i), .train_ready_i(train_ready_i),
    .train_valid_o(train_valid_o), .train_branch_type_o(train_branch_type_o),
    .train_pc_o(train_pc_o), .train_partial_o(train_partial_o),
    .train_npc_o(train_npc_o), .queue_full_o(queue_full_o)
`ifdef MUNTJAC_BTB_TRAIN_STATS_EN
    , .stat_trained_o(stat_trained_o), .stat_dropped_o(stat_dropped_o)
`endif
  );

  always #5 clk = ~clk;

  btb_train_req_t mq[$];
  int unsigned    m_trained = 0, m_dropped = 0;
  int             n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an ordered list of pending updates, occupancy = list length.
  task automatic model_update();
    int sz;
    bit pop, upd, inval, coal;
    btb_train_req_t r;
    sz  = mq.size();
    pop = (sz > 0) && train_ready_i;
    if (pop) m_trained++;
    if (flush_i) begin
      mq.delete();
      return;
    end
    upd = 0; inval = 0;
    if (resolve_valid_i) begin
      if (resolve_taken_i && !pred_hit_i) upd = 1;
      else if (resolve_taken_i && (resolve_npc_i >> 1) != (pred_npc_i >> 1)) upd = 1;
      else if (!resolve_taken_i && pred_hit_i) begin upd = 1; inval = 1; end
    end
    r.pc          = resolve_pc_i;
    r.partial     = resolve_partial_i;
    r.branch_type = inval ? BRANCH_NONE : resolve_branch_type_i;
    r.npc         = inval ? 64'd0 : (resolve_npc_i & ~64'd1);
    coal = upd && sz > 0 && (mq[sz-1].pc >> 2) == (resolve_pc_i >> 2) && !(sz == 1 && pop);
    if (pop) void'(mq.pop_front());
    if (coal) mq[mq.size()-1] = r;
    else if (upd) begin
      if (sz < DEPTH || pop) mq.push_back(r);
      else m_dropped++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (mq.size() > 0) begin
        chk("valid", train_valid_o, 1);
        chk("pc", train_pc_o, mq[0].pc);
        chk("npc", train_npc_o, mq[0].npc);
        chk("type", train_branch_type_o, mq[0].branch_type);
        chk("partial", train_partial_o, mq[0].partial);
      end else begin
        chk("valid", train_valid_o, 0);
      end
      chk("full", queue_full_o, mq.size() == DEPTH);
`ifdef MUNTJAC_BTB_TRAIN_STATS_EN
      chk("stat_trained", stat_trained_o, m_trained);
      chk("stat_dropped", stat_dropped_o, m_dropped);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic res(input logic [63:0] pc, input branch_type_e t, input logic tk,
                     input logic [63:0] npc, input logic hit, input logic [63:0] pnpc);
    resolve_valid_i = 1; resolve_pc_i = pc; resolve_branch_type_i = t;
    resolve_taken_i = tk; resolve_npc_i = npc; pred_hit_i = hit; pred_npc_i = pnpc;
    resolve_partial_i = 0;
    step();
    resolve_valid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    branch_type_e types [5];
    types = '{BRANCH_TAKEN, BRANCH_UNTAKEN, BRANCH_JUMP, BRANCH_CALL, BRANCH_RET};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", train_valid_o, 0);
    chk("rst_full", queue_full_o, 0);
    chk("rst_pc", train_pc_o, 0);
    rst_ni = 1;

    // Alloc: visible one cycle later, popped by ready.
    res(64'h1000, BRANCH_JUMP, 1, 64'h2000, 0, 0);
    chk("alloc_valid", train_valid_o, 1);
    chk("alloc_pc", train_pc_o, 64'h1000);
    chk("alloc_npc", train_npc_o, 64'h2000);
    chk("alloc_type", train_branch_type_o, BRANCH_JUMP);
    step();
    chk("alloc_popped", train_valid_o, 0);

    // Retarget: bit 0 difference ignored.
    res(64'h500, BRANCH_TAKEN, 1, 64'h3001, 1, 64'h3000);
    chk("bit0_ignored", train_valid_o, 0);
    res(64'h500, BRANCH_TAKEN, 1, 64'h3004, 1, 64'h3000);
    chk("retarget_npc", train_npc_o, 64'h3004);
    step();

    // Invalidate vs. nothing.
    res(64'h40, BRANCH_TAKEN, 0, 64'h44, 1, 64'h3000);
    chk("inval_type", train_branch_type_o, BRANCH_NONE);
    chk("inval_npc", train_npc_o, 0);
    chk("inval_pc", train_pc_o, 64'h40);
    step();
    res(64'h40, BRANCH_TAKEN, 0, 64'h44, 0, 0);
    chk("untaken_miss", train_valid_o, 0);

    // Fill, drop fifth, drain in order.
    train_ready_i = 0;
    for (int i = 1; i <= 5; i++) begin
      res(64'h100 * i, BRANCH_CALL, 1, 64'h9000 + i * 8, 0, 0);
      if (i == 4) chk("full_after_4", queue_full_o, 1);
    end
    chk("full_after_5", queue_full_o, 1);
`ifdef MUNTJAC_BTB_TRAIN_STATS_EN
    chk("dropped_one", stat_dropped_o, 1);
`endif
    train_ready_i = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_pc", train_pc_o, 64'h100 * i);
      step();
    end
    chk("drained", train_valid_o, 0);

    // Coalesce same PC.
    train_ready_i = 0;
    res(64'h80, BRANCH_JUMP, 1, 64'h100, 0, 0);
    res(64'h80, BRANCH_JUMP, 1, 64'h200, 0, 0);
    chk("coal_npc", train_npc_o, 64'h200);
    train_ready_i = 1;
    step();
    chk("coal_single", train_valid_o, 0);

    // Flush, then async reset with full queue.
    train_ready_i = 0;
    for (int i = 1; i <= 3; i++) res(64'h10 * i, BRANCH_JUMP, 1, 64'h700, 0, 0);
    flush_i = 1;
    step();
    flush_i = 0;
    chk("flush_valid", train_valid_o, 0);
    for (int i = 1; i <= 4; i++) res(64'h10 * i, BRANCH_JUMP, 1, 64'h700, 0, 0);
    chk("pre_rst_full", queue_full_o, 1);
    #2 rst_ni = 0;
    #1;
    chk("arst_valid", train_valid_o, 0);
    chk("arst_full", queue_full_o, 0);
    chk("arst_pc", train_pc_o, 0);
    chk("arst_npc", train_npc_o, 0);
    mq.delete(); m_trained = 0; m_dropped = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_ni = 1;

    // Random traffic over a small PC/target space to exercise coalescing and overflow.
    for (int c = 0; c < 3000; c++) begin
      resolve_valid_i       = ($urandom_range(0, 9) < 7);
      resolve_pc_i          = 64'($urandom_range(0, 15)) << 1;
      resolve_branch_type_i = types[$urandom_range(0, 4)];
      resolve_partial_i     = 1'($urandom);
      resolve_taken_i       = 1'($urandom);
      resolve_npc_i         = 64'($urandom_range(0, 7)) + 64'h4000;
      pred_hit_i            = 1'($urandom);
      pred_npc_i            = 64'($urandom_range(0, 7)) + 64'h4000;
      flush_i               = ($urandom_range(0, 99) < 3);
      train_ready_i         = ($urandom_range(0, 9) < 4);
      step();
    end
    resolve_valid_i = 0; flush_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muntjac_btb_trainer.md
Name: muntjac_btb_trainer

Overview:
Write-side companion to the branch target buffer. It takes resolved control-flow outcomes from the execute stage, compares each with the BTB prediction made at fetch, and decides whether a BTB update is needed. Required updates (allocate, retarget or invalidate) sit in a small queue and drain one per cycle onto the BTB train interface. Sits between the execute-stage branch resolution logic and the BTB.

Parameters:
AddrLen, 64, virtual address width; must match the BTB.
QueueDepth, 4, number of pending training entries; power of two, >= 2.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
resolve_valid_i  in  1  one resolved control-flow instruction this cycle
resolve_pc_i  in  AddrLen  PC of the resolved instruction
resolve_branch_type_i  in  branch_type_e  actual branch type
resolve_partial_i  in  1  instruction straddles the 4-byte fetch boundary
resolve_taken_i  in  1  actual direction
resolve_npc_i  in  AddrLen  actual target; bit 0 is ignored
pred_hit_i  in  1  BTB hit at fetch for this instruction
pred_npc_i  in  AddrLen  BTB-predicted target at fetch
flush_i  in  1  discard all queued, not-yet-issued updates
train_ready_i  in  1  BTB can accept a write; tied high when the BTB is idle
train_valid_o  out  1  update valid
train_branch_type_o  out  branch_type_e  type to store
train_pc_o  out  AddrLen  PC to index and tag
train_partial_o  out  1  partial flag to store
train_npc_o  out  AddrLen  target to store; bit 0 is always 0
queue_full_o  out  1  queue holds QueueDepth entries

Behaviour:
- Reset (async): queue empty, head and tail pointers 0, train_valid_o=0, all other outputs 0, queue_full_o=0.
- Decision is combinational on resolve_valid_i:
  - ALLOC: taken, pred_hit_i=0.
  - RETARGET: taken, pred_hit_i=1, resolve_npc_i[AddrLen-1:1] != pred_npc_i[AddrLen-1:1].
  - INVALIDATE: not taken, pred_hit_i=1. Writes branch_type encoding 0 (BRANCH_NONE) and npc 0.
  - Otherwise: no action.
- Enqueue happens on the edge after the decision, so latency from resolve to train_valid_o is 1 cycle when the queue is empty.
- The output is the queue head. An entry is popped on the edge where train_valid_o && train_ready_i. train_valid_o stays asserted and the payload stays stable until it is accepted.
- Coalescing: if the queue is non-empty and the incoming PC[AddrLen-1:2] equals the newest entry's PC[AddrLen-1:2], the newest entry is overwritten in place and no new entry is allocated.
  - This does not apply when the newest entry is also the head and is being popped this cycle. In that case the incoming update is enqueued normally.
- Full: if full and no pop happens this cycle, the new update is dropped (the newest update is lost). If full and a pop happens this cycle, the enqueue succeeds.
- Simultaneous push and pop leave the occupancy unchanged.
- Pointers wrap modulo QueueDepth. Occupancy is tracked with an extra wrap bit so that full and empty can be told apart.
- flush_i clears the queue on the next edge. It takes priority over a same-cycle enqueue, and a same-cycle pop is a don't-care.
  - The head being presented in the flush cycle may still be accepted by the BTB; this is harmless because a BTB write is idempotent.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
MUNTJAC_BTB_TRAIN_STATS_EN.
- Defined: adds outputs stat_trained_o[31:0] and stat_dropped_o[31:0].
  - stat_trained_o counts accepted train handshakes.
  - stat_dropped_o counts updates lost because the queue was full.
  - Both reset to 0 and saturate at all-ones.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared muntjac_pkg: the existing branch_type_e, plus a new btb_train_req_t packed struct {pc, branch_type, partial, npc}.
- One natural sub-module, muntjac_btb_train_queue: a generic circular FIFO with overwrite-newest support, parameterised by depth and payload type.

Test Plan:
- Taken jump at pc=0x1000 to 0x2000 with pred_hit=0 -> 1 cycle later train_valid_o=1, pc=0x1000, npc=0x2000, type as resolved; popped with ready=1.
- Taken branch with hit, pred_npc=0x3000, actual 0x3001 -> no training, because bit 0 is ignored; actual 0x3004 -> RETARGET with npc=0x3004.
- Not-taken with pred_hit=1 at pc=0x40 -> entry with type BRANCH_NONE and npc=0; not-taken with pred_hit=0 -> nothing.
- train_ready_i=0 and five distinct allocs at QueueDepth=4 -> queue_full_o=1 after the 4th, 5th dropped (stat_dropped_o=1 when enabled); after ready goes high the four entries drain in FIFO order, one per cycle.
- Two back-to-back updates to pc=0x80 (targets 0x100 then 0x200) with ready=0 -> a single entry with npc=0x200.
- Queue holding 3 entries, then flush_i pulse -> train_valid_o=0 the next cycle; async reset with the queue full -> all outputs 0 immediately.
